// File: rtl/cb_mem_bank_prog_ctrl.sv
// ---------------------------------------------------------------------------
// cb_mem_bank_prog_ctrl
//
// Programming controller for one connection block's flat bl/wl configuration
// bus.  The block has NUM_CELLS SRAM cells arranged as NUM_CELLS/GROUP_W
// mux-memory groups.  One configuration word per group is taken over a
// valid/ready stream.  For each word the controller drives the bitlines,
// strobes that group's wordlines for WL_PULSE_CYCLES, then holds one cycle.
//
// Ports
//   prog_clk    programming clock, rising edge
//   prog_reset  synchronous active-high reset
//   start       one-cycle request for a full pass (honoured only in IDLE)
//   abort       synchronous abort of an in-progress pass
//   cfg_data    configuration word, bit k -> cell grp_idx*GROUP_W+k
//   cfg_valid   cfg_data valid
//   cfg_ready   controller accepts a word this cycle
//   bl / wl     bitline data / wordline strobes to the connection block
//   busy        pass in progress
//   done        one-cycle pulse when a pass completes
//   grp_idx     index of the group being programmed
//
// Optional feature, macro CB_PROG_PARITY_CHECK_EN:
//   adds cfg_parity (in) and parity_err (out).  Each accepted word must have
//   odd parity over {cfg_data, cfg_parity}; a bad word ends the pass without
//   touching the wordlines and sets parity_err until the next start/reset.
//
// State table
//   S_IDLE  | no pass in progress, bus quiet
//   S_LOAD  | waiting for the current group's word (cfg_ready=1)
//   S_SETUP | bitlines settle, wordlines low
//   S_PULSE | current group's wordlines high for WL_PULSE_CYCLES
//   S_HOLD  | wordlines low, bitlines held
//   S_DONE  | done pulse, returns to IDLE
// ---------------------------------------------------------------------------
module cb_mem_bank_prog_ctrl #(
  parameter int NUM_CELLS       = 66,
  parameter int GROUP_W         = 6,
  parameter int WL_PULSE_CYCLES = 2,
  localparam int NG    = NUM_CELLS / GROUP_W,
  localparam int IDX_W = (NG > 1) ? $clog2(NG) : 1,
  localparam int CNT_W = (WL_PULSE_CYCLES > 1) ? $clog2(WL_PULSE_CYCLES) : 1
) (
  input  logic                 prog_clk,
  input  logic                 prog_reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [GROUP_W-1:0]   cfg_data,
  input  logic                 cfg_valid,
`ifdef CB_PROG_PARITY_CHECK_EN
  input  logic                 cfg_parity,
  output logic                 parity_err,
`endif
  output logic                 cfg_ready,
  output logic [NUM_CELLS-1:0] bl,
  output logic [NUM_CELLS-1:0] wl,
  output logic                 busy,
  output logic                 done,
  output logic [IDX_W-1:0]     grp_idx
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SETUP = 3'd2,
    S_PULSE = 3'd3,
    S_HOLD  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [IDX_W-1:0]     r_grp, w_grp_nxt;
  logic [NUM_CELLS-1:0] r_bl, w_bl_nxt;
  logic [NUM_CELLS-1:0] r_wl, w_wl_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 r_done, w_done_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;

  logic [31:0]          w_shamt;
  logic [NUM_CELLS-1:0] w_grp_bl;
  logic [NUM_CELLS-1:0] w_grp_wl;
  logic                 w_parity_ok;

`ifdef CB_PROG_PARITY_CHECK_EN
  logic r_perr, w_perr_nxt;
  assign w_parity_ok = ^{cfg_data, cfg_parity};
  assign parity_err  = r_perr;
`else
  assign w_parity_ok = 1'b1;
`endif

  // Bit offset of the current group on the flat bus.
  assign w_shamt  = 32'(r_grp) * 32'(GROUP_W);
  assign w_grp_bl = NUM_CELLS'(cfg_data) << w_shamt;
  assign w_grp_wl = NUM_CELLS'({GROUP_W{1'b1}}) << w_shamt;

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      r_state <= S_IDLE;
      r_grp   <= '0;
      r_bl    <= '0;
      r_wl    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
`ifdef CB_PROG_PARITY_CHECK_EN
      r_perr  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_grp   <= w_grp_nxt;
      r_bl    <= w_bl_nxt;
      r_wl    <= w_wl_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_cnt   <= w_cnt_nxt;
`ifdef CB_PROG_PARITY_CHECK_EN
      r_perr  <= w_perr_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grp_nxt   = r_grp;
    w_bl_nxt    = r_bl;
    w_wl_nxt    = '0;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_cnt_nxt   = r_cnt;
`ifdef CB_PROG_PARITY_CHECK_EN
    w_perr_nxt  = r_perr;
`endif

    if (abort && (r_state != S_IDLE)) begin
      // Abort outranks any handshake in the same cycle; the word is dropped.
      w_state_nxt = S_IDLE;
      w_grp_nxt   = '0;
      w_bl_nxt    = '0;
      w_busy_nxt  = 1'b0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_bl_nxt   = '0;
          w_busy_nxt = 1'b0;
          if (start && !abort) begin
            w_state_nxt = S_LOAD;
            w_grp_nxt   = '0;
            w_busy_nxt  = 1'b1;
`ifdef CB_PROG_PARITY_CHECK_EN
            w_perr_nxt  = 1'b0;
`endif
          end
        end
        S_LOAD: begin
          if (cfg_valid) begin
            if (w_parity_ok) begin
              w_bl_nxt    = w_grp_bl;
              w_state_nxt = S_SETUP;
            end else begin
              w_state_nxt = S_IDLE;
              w_grp_nxt   = '0;
              w_bl_nxt    = '0;
              w_busy_nxt  = 1'b0;
`ifdef CB_PROG_PARITY_CHECK_EN
              w_perr_nxt  = 1'b1;
`endif
            end
          end
        end
        S_SETUP: begin
          w_state_nxt = S_PULSE;
          w_wl_nxt    = w_grp_wl;
          w_cnt_nxt   = CNT_W'(WL_PULSE_CYCLES - 1);
        end
        S_PULSE: begin
          // Down-counter loaded on entry; the terminal count ends the strobe.
          if (r_cnt == '0) begin
            w_state_nxt = S_HOLD;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
            w_wl_nxt  = w_grp_wl;
          end
        end
        S_HOLD: begin
          w_bl_nxt = '0;
          if (r_grp == IDX_W'(NG - 1)) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
          end else begin
            w_state_nxt = S_LOAD;
            w_grp_nxt   = r_grp + IDX_W'(1);
          end
        end
        S_DONE: begin
          w_state_nxt = S_IDLE;
          w_grp_nxt   = '0;
          w_bl_nxt    = '0;
          w_busy_nxt  = 1'b0;
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_grp_nxt   = '0;
          w_bl_nxt    = '0;
          w_busy_nxt  = 1'b0;
        end
      endcase
    end
  end

  assign cfg_ready = (r_state == S_LOAD);
  assign bl        = r_bl;
  assign wl        = r_wl;
  assign busy      = r_busy;
  assign done      = r_done;
  assign grp_idx   = r_grp;

endmodule

// File: tb/tb_cb_mem_bank_prog_ctrl.sv
module tb_cb_mem_bank_prog_ctrl;

  localparam int NC = 66;
  localparam int GW = 6;
  localparam int WP = 2;
  localparam int NG = NC / GW;

  logic          prog_clk = 1'b0;
  logic          prog_reset;
  logic          start;
  logic          abort;
  logic [GW-1:0] cfg_data;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [NC-1:0] bl;
  logic [NC-1:0] wl;
  logic          busy;
  logic          done;
  logic [3:0]    grp_idx;
`ifdef CB_PROG_PARITY_CHECK_EN
  logic          cfg_parity;
  logic          parity_err;
`endif

  cb_mem_bank_prog_ctrl #(
    .NUM_CELLS(NC), .GROUP_W(GW), .WL_PULSE_CYCLES(WP)
  ) dut (
    .prog_clk  (prog_clk),
    .prog_reset(prog_reset),
    .start     (start),
    .abort     (abort),
    .cfg_data  (cfg_data),
    .cfg_valid (cfg_valid),
`ifdef CB_PROG_PARITY_CHECK_EN
    .cfg_parity(cfg_parity),
    .parity_err(parity_err),
`endif
    .cfg_ready (cfg_ready),
    .bl        (bl),
    .wl        (wl),
    .busy      (busy),
    .done      (done),
    .grp_idx   (grp_idx)
  );

  always #5 prog_clk = ~prog_clk;

  int cyc = 0;
  always @(posedge prog_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected wordline pulse: which group, what bus contents, first cycle, length.
  typedef struct {
    logic [NC-1:0] wl;
    logic [NC-1:0] bl;
    int            grp;
    int            cyc;
    int            len;
  } pulse_t;

  pulse_t pq[$];
  int     dq[$];

  // Monitor: pops an expectation whenever the DUT shows a pulse or done.
  pulse_t cur;
  bit     in_p = 1'b0;
  int     plen = 0;

  always @(negedge prog_clk) begin
    if (wl != '0) begin
      chk("busy_in_pulse", busy, 1);
      if (!in_p) begin
        checks++;
        if (pq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: got wl=%0h expected none (cycle %0d)", wl, cyc);
          cur.wl = wl; cur.bl = bl; cur.grp = 0; cur.cyc = cyc; cur.len = WP;
        end else begin
          cur = pq.pop_front();
          chk("pulse_start_cyc", cyc, cur.cyc);
          chk("pulse_grp", grp_idx, cur.grp);
        end
        in_p = 1'b1;
        plen = 1;
      end else begin
        plen++;
      end
      chk("pulse_wl", wl, cur.wl);
      chk("pulse_bl", bl, cur.bl);
    end else if (in_p) begin
      in_p = 1'b0;
      chk("pulse_len", plen, cur.len);
    end
    if (done === 1'b1) begin
      checks++;
      if (dq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got done=1 expected 0 (cycle %0d)", cyc);
      end else begin
        chk("done_cyc", cyc, dq.pop_front());
      end
    end
  end

  function automatic logic [NC-1:0] grp_mask(input int g);
    logic [NC-1:0] m;
    m = NC'(6'h3F);
    return m << (GW * g);
  endfunction

  function automatic logic [NC-1:0] grp_word(input logic [GW-1:0] w, input int g);
    logic [NC-1:0] m;
    m = NC'(w);
    return m << (GW * g);
  endfunction

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge prog_clk);
    #1;
  endtask

  // One programming pass.  Negative group arguments disable that event.
  task automatic pass(input bit directed, input int stall_grp, input int stall_n,
                      input int abort_grp, input int reset_grp, input int xstart_grp,
                      input bit rnd_stall);
    int            acc_c, first_c, stalls, n, done_c;
    bit            got;
    logic [GW-1:0] w;
    pulse_t        p;
    stalls  = 0;
    first_c = 0;
    acc_c   = 0;
    @(posedge prog_clk); #1 start = 1'b1;
    @(posedge prog_clk); #1 start = 1'b0;
    for (int g = 0; g < NG; g++) begin
      w = directed ? (6'h2A ^ 6'(g)) : 6'($urandom);
      cfg_data = w;
`ifdef CB_PROG_PARITY_CHECK_EN
      cfg_parity = ~(^w);
`endif
      n = (g == stall_grp) ? stall_n : ((rnd_stall && g > 0) ? int'($urandom_range(0, 3)) : 0);
      if (n > 0) begin
        cfg_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
          @(negedge prog_clk);
          if (cfg_ready) got = 1'b1;
          else begin @(posedge prog_clk); #1; end
        end
        chk("ready_before_stall", got, 1);
        for (int k = 0; k < n; k++) begin
          chk("ready_in_stall", cfg_ready, 1);
          chk("wl_in_stall", wl, 0);
          @(posedge prog_clk); #1;
          if (k < n - 1) @(negedge prog_clk);
        end
        stalls += n;
      end
      cfg_valid = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge prog_clk);
        if (g == 0 && k == 0) begin
          chk("busy_after_start", busy, 1);
`ifdef CB_PROG_PARITY_CHECK_EN
          chk("perr_clear_on_start", parity_err, 0);
`endif
        end
        if (cfg_ready) begin got = 1'b1; acc_c = cyc; end
        else begin @(posedge prog_clk); #1; end
      end
      chk("handshake_seen", got, 1);
      if (!got) begin
        cfg_valid = 1'b0;
        return;
      end
      chk("grp_at_accept", grp_idx, g);
      if (g == 0) first_c = acc_c;
      if (g == abort_grp) begin
        @(posedge prog_clk); #1 abort = 1'b1; cfg_valid = 1'b0;
        @(posedge prog_clk); #1 abort = 1'b0;
        @(negedge prog_clk);
        chk("abort_busy", busy, 0);
        chk("abort_wl", wl, 0);
        chk("abort_bl", bl, 0);
        chk("abort_grp", grp_idx, 0);
        chk("abort_ready", cfg_ready, 0);
        idle_cycles(WP + 6);
        return;
      end
      p.wl = grp_mask(g); p.bl = grp_word(w, g); p.grp = g; p.cyc = acc_c + 2;
      p.len = (g == reset_grp) ? 1 : WP;
      pq.push_back(p);
      if (g == reset_grp) begin
        @(posedge prog_clk); #1 cfg_valid = 1'b0;
        @(posedge prog_clk); #1 prog_reset = 1'b1;
        @(posedge prog_clk); #1 prog_reset = 1'b0;
        @(negedge prog_clk);
        chk("rst_wl", wl, 0);
        chk("rst_bl", bl, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", cfg_ready, 0);
        chk("rst_grp", grp_idx, 0);
        idle_cycles(WP + 6);
        return;
      end
      @(posedge prog_clk); #1;
      if (g == xstart_grp) begin
        start = 1'b1;
        @(posedge prog_clk); #1 start = 1'b0;
      end
      if (g == NG - 1) dq.push_back(acc_c + WP + 3);
    end
    cfg_valid = 1'b0;
    got = 1'b0;
    done_c = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge prog_clk);
      if (done) begin got = 1'b1; done_c = cyc; end
    end
    chk("done_seen", got, 1);
    chk("pass_cycles", done_c - first_c, NG * (WP + 3) + stalls);
    chk("busy_at_done", busy, 0);
    chk("bl_at_done", bl, 0);
    @(negedge prog_clk);
    chk("done_single", done, 0);
    chk("pulses_consumed", pq.size(), 0);
    idle_cycles(2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    prog_reset = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    cfg_data   = '0;
    cfg_valid  = 1'b0;
`ifdef CB_PROG_PARITY_CHECK_EN
    cfg_parity = 1'b0;
`endif
    repeat (3) @(posedge prog_clk);
    #1 prog_reset = 1'b0;
    @(negedge prog_clk);
    chk("reset_bl", bl, 0);
    chk("reset_wl", wl, 0);
    chk("reset_ready", cfg_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_grp", grp_idx, 0);
`ifdef CB_PROG_PARITY_CHECK_EN
    chk("reset_perr", parity_err, 0);
`endif
    idle_cycles(2);

    pass(1'b1, -1, 0, -1, -1, -1, 1'b0);   // directed words, valid always high
    pass(1'b0, 3, 10, -1, -1, -1, 1'b0);   // backpressure on group 3
    pass(1'b0, -1, 0, 7, -1, -1, 1'b0);    // abort in SETUP of group 7
    pass(1'b0, -1, 0, -1, -1, -1, 1'b0);   // restart from group 0
    pass(1'b0, -1, 0, -1, -1, 2, 1'b0);    // start while busy is ignored
    pass(1'b0, -1, 0, -1, 5, -1, 1'b0);    // reset during group 5 pulse
    for (int i = 0; i < 4; i++) pass(1'b0, -1, 0, -1, -1, -1, 1'b1);

    // start and abort together in IDLE: abort wins
    @(posedge prog_clk); #1 start = 1'b1; abort = 1'b1;
    @(posedge prog_clk); #1 start = 1'b0; abort = 1'b0;
    @(negedge prog_clk);
    chk("start_abort_busy", busy, 0);
    chk("start_abort_ready", cfg_ready, 0);
    idle_cycles(2);

`ifdef CB_PROG_PARITY_CHECK_EN
    begin
      bit got;
      @(posedge prog_clk); #1 start = 1'b1;
      @(posedge prog_clk); #1 start = 1'b0;
      cfg_data = 6'b000111; cfg_parity = 1'b1; cfg_valid = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge prog_clk);
        if (cfg_ready) got = 1'b1;
        else begin @(posedge prog_clk); #1; end
      end
      chk("perr_handshake", got, 1);
      @(posedge prog_clk); #1 cfg_valid = 1'b0;
      @(negedge prog_clk);
      chk("perr_set", parity_err, 1);
      chk("perr_busy", busy, 0);
      chk("perr_wl", wl, 0);
      chk("perr_bl", bl, 0);
      idle_cycles(4);
      @(negedge prog_clk);
      chk("perr_sticky", parity_err, 1);
      idle_cycles(1);
      pass(1'b0, -1, 0, -1, -1, -1, 1'b0);
    end
`endif

    idle_cycles(5);
    chk("final_pulse_queue", pq.size(), 0);
    chk("final_done_queue", dq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
